// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state type, geometry defaults and address split for the memory-stage data cache
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;
  localparam int IDX_BITS_DEF = 3;
  localparam int TAG_W_DEF = 64 - IDX_BITS_DEF - 3;
  localparam int LINES_DEF = 1 << IDX_BITS_DEF;
  // tag_sel=1 yields the tag field, 0 the index field; the caller truncates to the field width
  function automatic logic [63:0] addr_fields(input logic [63:0] a, input int ib, input logic tag_sel);
    return a >> (tag_sel ? ib + 3 : 3);
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage with combinational read, synchronous write and clear-all-valid
module dcache_array import dcache_pkg::*; #(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int TAG_W = 64 - IDX_BITS - 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [63:0]         rd_data,
  input  logic                we,
  input  logic                set_valid,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [63:0]         wr_data
);
  localparam int LINES = 1 << IDX_BITS;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [63:0] data_q [LINES];
  logic [63:0] data_d [LINES];
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    if (we) begin
      valid_d[wr_idx] = valid_q[wr_idx] | set_valid;
      tag_d[wr_idx] = wr_tag;
      data_d[wr_idx] = wr_data;
    end
    if (clr) valid_d = '0;
  end
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q <= tag_d;
    data_q <= data_d;
  end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: MEM stage with direct-mapped write-through no-allocate dcache and branch resolve
module mem_stage_dcache import dcache_pkg::*; #(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      addr,
  input  logic [63:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             zero_flag,
  output logic             hit,
  output logic [63:0]      read_data,
  output logic             pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [63:0]      mem_rdata,
  output logic [CNT_W-1:0] rd_hit_cnt,
  output logic [CNT_W-1:0] rd_miss_cnt,
  output logic [CNT_W-1:0] wr_cnt
);
  localparam int TAG_W = 64 - IDX_BITS - 3;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
  logic [CNT_W-1:0] rh_q, rh_d, rm_q, rm_d, wc_q, wc_d;
  logic [63:0] lk_addr, arr_data, arr_wdata;
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag, arr_tag;
  logic arr_valid, lk_hit, arr_we;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
  // once a request is out, the registered line address drives lookup and update
  assign lk_addr = (state_q == IDLE) ? addr : addr_q;
  assign lk_idx = IDX_BITS'(addr_fields(lk_addr, IDX_BITS, 1'b0));
  assign lk_tag = TAG_W'(addr_fields(lk_addr, IDX_BITS, 1'b1));
  assign lk_hit = arr_valid && (arr_tag == lk_tag);
  assign arr_wdata = (state_q == FILL) ? mem_rdata : wdata_q;
  dcache_array #(.IDX_BITS(IDX_BITS), .TAG_W(TAG_W)) u_array (
    .clk(clk), .clr(!rst_n), .rd_idx(lk_idx), .rd_valid(arr_valid), .rd_tag(arr_tag),
    .rd_data(arr_data), .we(arr_we), .set_valid(state_q == FILL), .wr_idx(lk_idx),
    .wr_tag(lk_tag), .wr_data(arr_wdata)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    resp_d = resp_q;
    rh_d = rh_q;
    rm_d = rm_q;
    wc_d = wc_q;
    arr_we = 1'b0;
    hit = 1'b1;
    read_data = '0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          hit = 1'b0;
          state_d = WRITE;
          req_d = 1'b1;
          we_d = 1'b1;
          addr_d = {addr[63:3], 3'b000};
          wdata_d = write_data;
          wc_d = sat_inc(wc_q);
        end else if (mem_read && lk_hit) begin
          read_data = arr_data;
          rh_d = sat_inc(rh_q);
        end else if (mem_read) begin
          hit = 1'b0;
          state_d = FILL;
          req_d = 1'b1;
          we_d = 1'b0;
          addr_d = {addr[63:3], 3'b000};
          rm_d = sat_inc(rm_q);
        end
      end
      FILL: begin
        hit = 1'b0;
        if (mem_ack) begin
          arr_we = 1'b1;
          resp_d = mem_rdata;
          req_d = 1'b0;
          state_d = RESP;
        end
      end
      WRITE: begin
        hit = 1'b0;
        if (mem_ack) begin
          arr_we = lk_hit;
          req_d = 1'b0;
          state_d = RESP;
        end
      end
      default: begin
        read_data = we_q ? '0 : resp_q;
        state_d = IDLE;
      end
    endcase
    if (!rst_n) begin
      hit = 1'b1;
      read_data = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      rh_q <= '0;
      rm_q <= '0;
      wc_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      rh_q <= rh_d;
      rm_q <= rm_d;
      wc_q <= wc_d;
    end
  end
  assign pc_src = branch & zero_flag;
  assign mem_req = req_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_hit_cnt = rh_q;
  assign rd_miss_cnt = rm_q;
  assign wr_cnt = wc_q;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb_mem_stage_dcache: directed and random loads/stores checked against a line-level cache model
module tb_mem_stage_dcache;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] addr = '0, write_data = '0, mem_rdata = '0;
  logic mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0, zero_flag = 1'b0, mem_ack = 1'b0;
  logic hit, pc_src, mem_req, mem_we;
  logic [63:0] read_data, mem_addr, mem_wdata;
  logic [CW-1:0] rd_hit_cnt, rd_miss_cnt, wr_cnt;
  int errors = 0, checks = 0;
  int nrh = 0, nrm = 0, nwc = 0;
  bit mvalid [8];
  logic [63:0] mtag [8];
  logic [63:0] mdata [8];
  logic [63:0] bmem [logic [63:0]];

  always #5 clk = ~clk;

  mem_stage_dcache #(.IDX_BITS(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .zero_flag(zero_flag), .hit(hit),
    .read_data(read_data), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_hit_cnt(rd_hit_cnt), .rd_miss_cnt(rd_miss_cnt), .wr_cnt(wr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c == CMAX) ? CMAX : c + 1;
  endfunction

  task automatic chk_cnts();
    chk("rd_hit_cnt", 64'(rd_hit_cnt), 64'(nrh));
    chk("rd_miss_cnt", 64'(rd_miss_cnt), 64'(nrm));
    chk("wr_cnt", 64'(wr_cnt), 64'(nwc));
  endtask

  // one access from IDLE; dly = FILL/WRITE cycles spent before the ack cycle
  task automatic access(input logic [63:0] a, input bit rd, input bit wr, input logic [63:0] wd, input int dly);
    int idx = int'((a >> 3) % 8);
    logic [63:0] tg = a >> 6;
    logic [63:0] line = a & ~64'h7;
    bit mhit = mvalid[idx] && (mtag[idx] == tg);
    logic [63:0] fill;
    @(negedge clk);
    addr = a; mem_read = rd; mem_write = wr; write_data = wd;
    branch = 1'($urandom); zero_flag = 1'($urandom);
    #1;
    chk("pc_src", 64'(pc_src), 64'(branch & zero_flag));
    if (!rd && !wr) begin
      chk("idle_hit", 64'(hit), 64'd1);
      return;
    end
    if (rd && !wr && mhit) begin
      chk("rd_hit", 64'(hit), 64'd1);
      chk("rd_hit_data", read_data, mdata[idx]);
      @(posedge clk); #1;
      nrh = sat(nrh);
      chk_cnts();
      return;
    end
    chk("miss_stall", 64'(hit), 64'd0);
    @(posedge clk); #1;
    if (wr) nwc = sat(nwc); else nrm = sat(nrm);
    chk_cnts();
    chk("req", 64'(mem_req), 64'd1);
    chk("req_we", 64'(mem_we), 64'(wr));
    chk("req_addr", mem_addr, line);
    if (wr) chk("req_wdata", mem_wdata, wd);
    repeat (dly) begin
      @(negedge clk); #1;
      chk("wait_stall", 64'(hit), 64'd0);
      chk("wait_req", 64'(mem_req), 64'd1);
      chk("wait_addr", mem_addr, line);
      @(posedge clk);
    end
    fill = bmem.exists(line) ? bmem[line] : {$urandom, $urandom};
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = wr ? {$urandom, $urandom} : fill;
    #1;
    chk("ack_stall", 64'(hit), 64'd0);
    if (wr) chk("ack_wdata", mem_wdata, wd);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("resp_req", 64'(mem_req), 64'd0);
    chk("resp_hit", 64'(hit), 64'd1);
    chk("resp_data", read_data, wr ? 64'd0 : fill);
    if (wr) begin
      bmem[line] = wd;
      if (mhit) mdata[idx] = wd;
    end else begin
      bmem[line] = fill;
      mvalid[idx] = 1'b1; mtag[idx] = tg; mdata[idx] = fill;
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_hit", 64'(hit), 64'd1);
    chk("rst_rdata", read_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk_cnts();
    @(negedge clk); rst_n = 1'b1;
    // cold load, then repeat hit
    bmem[64'h40] = 64'hDEAD_BEEF;
    access(64'h40, 1, 0, 0, 2);
    access(64'h40, 1, 0, 0, 0);
    chk("cold_miss_cnt", 64'(rd_miss_cnt), 64'd1);
    chk("cold_hit_cnt", 64'(rd_hit_cnt), 64'd1);
    // store to cached line, then load sees it
    access(64'h44, 0, 1, 64'h1234, 1);
    access(64'h40, 1, 0, 0, 0);
    chk("store_hit_data", read_data, 64'h1234);
    // conflict on same index
    access(64'h80, 1, 0, 0, 1);
    access(64'h40, 1, 0, 0, 0);
    // store miss does not allocate
    access(64'h200, 0, 1, {$urandom, $urandom}, 0);
    access(64'h200, 1, 0, 0, 0);
    // read+write priority
    access(64'h48, 1, 1, {$urandom, $urandom}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      branch = 1'(i >> 1); zero_flag = 1'(i);
      #1;
      chk("branch", 64'(pc_src), 64'((i >> 1) & i & 1));
    end
    // reset mid-fill
    @(negedge clk);
    addr = 64'h300; mem_read = 1'b1;
    @(posedge clk); #1;
    chk("mid_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0; addr = 64'h40;
    #1;
    chk("rst_mid_hit", 64'(hit), 64'd1);
    chk("rst_mid_rdata", read_data, 64'd0);
    @(posedge clk); #1;
    nrh = 0; nrm = 0; nwc = 0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk_cnts();
    @(negedge clk);
    rst_n = 1'b1; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_ack_req", 64'(mem_req), 64'd0);
    chk("stray_ack_hit", 64'(hit), 64'd1);
    chk_cnts();
    access(64'h40, 1, 0, 0, 0);
    access(64'h80, 1, 0, 0, 0);
    // random traffic, long enough to saturate the narrow counters
    for (int n = 0; n < 80; n++) begin
      int r = int'($urandom_range(0, 9));
      logic [63:0] a = (64'($urandom_range(0, 1)) << 40) + 64'($urandom_range(0, 3)) * 64 +
                       64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      access(a, (r < 5) || (r == 8), (r >= 5) && (r <= 8), {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end
    chk("sat_hit", 64'(rd_hit_cnt), 64'(CMAX));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_dcache.md
# mem_stage_dcache

Memory stage of the pipelined ARM core, directly downstream of the EX/MEM pipeline register. It consumes that register's outputs and services loads and stores through a direct-mapped, write-through, no-write-allocate data cache. Misses and stores go to a backing memory over a req/ack handshake. The `hit` output is the pipeline stall signal that gates the upstream EX/MEM register and earlier stages. The block also resolves the branch decision, `pc_src`.

## Interface
Parameters:
- `IDX_BITS`, default 3: index width. The cache has 2^IDX_BITS lines of one 64-bit doubleword each.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1: the single clock. All state updates on posedge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `addr`  in  64: byte address, taken from the EX/MEM ALU result.
- `write_data`  in  64: store data, taken from EX/MEM read-data-2.
- `mem_read`  in  1: load request.
- `mem_write`  in  1: store request.
- `branch`  in  1: branch instruction flag.
- `zero_flag`  in  1: ALU zero flag.
- `hit`  out  1: 1 means the stage is complete and the pipeline may advance; 0 means stall.
- `read_data`  out  64: load result, valid when `hit`=1 and `mem_read`=1.
- `pc_src`  out  1: equals `branch & zero_flag`, purely combinational.
- `mem_req`  out  1: backing-memory request, registered.
- `mem_we`  out  1: 1 for a write request, 0 for a line fill.
- `mem_addr`  out  64: doubleword-aligned request address, `{addr[63:3],3'b000}`.
- `mem_wdata`  out  64: write data for the backing memory.
- `mem_ack`  in  1: one-cycle completion pulse from the backing memory.
- `mem_rdata`  in  64: fill data, valid when `mem_ack`=1.
- `rd_hit_cnt`, `rd_miss_cnt`, `wr_cnt`  out  CNT_W each: saturating performance counters.

## Operation
- Address split:
  - offset = `addr[2:0]`, ignored; all accesses are 64-bit aligned.
  - index = `addr[IDX_BITS+2:3]`.
  - tag = `addr[63:IDX_BITS+3]`.
- A lookup hits when `valid[index]` is set and `tag_ram[index]` equals the address tag.
- If `mem_read` and `mem_write` are both 1, the access is treated as a write and `read_data` is 0.
- States: IDLE, FILL, WRITE, RESP.
- IDLE:
  - With no access, `hit`=1.
  - On a read that hits the cache, `hit`=1 and `read_data` comes combinationally from the data array. `rd_hit_cnt` increments.
  - On a read miss, `hit`=0. Next state is FILL; `mem_req`=1 and `mem_we`=0 are registered, and `rd_miss_cnt` increments.
  - On a write, `hit`=0. Next state is WRITE; `mem_req`=1, `mem_we`=1 and `mem_wdata`=`write_data` are registered, and `wr_cnt` increments.
- FILL:
  - `hit`=0 and `mem_req` is held.
  - On `mem_ack`: write `mem_rdata` into the line, set the tag and the valid bit, capture `mem_rdata` into the response buffer, drop `mem_req`, and go to RESP.
- WRITE:
  - `hit`=0 and `mem_req` is held.
  - On `mem_ack`: if the line hits, update its data (no allocate on a miss). Drop `mem_req` and go to RESP.
- RESP:
  - `hit`=1 for exactly one cycle.
  - `read_data` = response buffer for a fill, 0 for a write.
  - Next state is always IDLE. This state keeps an access that is still presented from being re-issued before the EX/MEM register updates on negedge.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable from the request edge until the edge at which `mem_ack` is sampled.
- Counters saturate at all-ones and do not wrap.
- Reset:
  - Clears every valid bit, every counter, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and the response buffer.
  - State returns to IDLE.
  - Reset in the middle of a FILL or WRITE abandons the transaction. A `mem_ack` arriving in IDLE is ignored.
- Output values during reset: `hit`=1 and `read_data`=0 (no access is pending because all lines are invalid). `pc_src` follows its inputs.

## Timing
- Read hit: zero added cycles; `hit` and `read_data` are combinational in the same cycle.
- Read miss, minimum 2 cycles:
  - Edge E0: IDLE→FILL.
  - E1: `mem_ack` sampled, FILL→RESP.
  - `hit`=1 during the E1–E2 cycle.
  - Each extra cycle of `mem_ack` delay adds one cycle.
- Store: the same 2-cycle minimum through WRITE and RESP.
- Back-to-back accesses: the earliest new lookup happens in IDLE after RESP. A load to a just-filled line hits.
- `mem_ack` is only ever sampled in FILL or WRITE.

## Structure
- `dcache_pkg` holds:
  - the state enum (IDLE, FILL, WRITE, RESP);
  - the `IDX_BITS` default;
  - the tag-width and line-count localparams;
  - an `addr_fields` split function.
- One sub-module, `dcache_array`, holds the valid, tag and data storage. It has:
  - a combinational read port (index → valid, tag, data);
  - a synchronous write port (index, tag, data, set_valid);
  - a synchronous clear-all-valid input driven by reset.
- The FSM, counters, handshake registers and `pc_src` live in the top module.

## Test plan
- Cold load: `addr`=0x40 with `mem_read`; `mem_ack` after 3 cycles with `mem_rdata`=0xDEAD_BEEF.
  - `hit`=0 for 4 cycles, then `hit`=1 for one cycle with `read_data`=0xDEAD_BEEF.
  - A repeat load of 0x40 hits with zero stall.
  - `rd_miss_cnt`=1, `rd_hit_cnt`=1.
- Store to a cached line: after filling 0x40, store 0x1234 to 0x44.
  - `mem_req`=1, `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x1234.
  - After ack, a load of 0x40 hits and returns 0x1234.
- Conflict: with `IDX_BITS`=3, load 0x40 and then 0x80 (same index, different tag).
  - The second load misses and refills.
  - A third load of 0x40 misses again.
- Store miss: a store to uncached 0x200 completes via WRITE/RESP. A following load of 0x200 misses (no allocate).
- Reset mid-fill: drive `rst_n`=0 while in FILL, then pulse `mem_ack` after release.
  - `mem_req`=0 after the reset edge.
  - The ack is ignored.
  - Counters are 0, and all previously cached lines miss.
- Branch and priority:
  - `branch`=1, `zero_flag`=1 gives `pc_src`=1; `zero_flag`=0 gives 0.
  - With `mem_read`=`mem_write`=1, a write is issued and `read_data`=0 in RESP.
